spi_frame_receiver: RTL and testbench

Synthesizable SPI target that captures one frame from the MCU (spi_sck, sdi, ce) into a parallel register. Inputs are synchronized into the system clock domain and sck rising edges are detected. Data is shifted in MSB first, and a full frame is published with a one-cycle valid strobe. It sits between the MCU pins and the display frame buffer, at the opposite end of the link from the bench SPI sender.

---
 rtl/spi_rx_pkg.sv | 17 +
 rtl/spi_rx_sync.sv | 34 +++
 rtl/spi_frame_receiver.sv | 122 ++++++++++++
 tb/tb_spi_frame_receiver.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and sizing helpers for the SPI frame receiver.
package spi_rx_pkg;

  localparam int unsigned FRAME_BITS_DEF = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of a counter that must be able to hold the value 'bits'.
  function automatic int unsigned cnt_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/spi_rx_sync.sv
// Input synchronizer for the SPI pins; the edge line also gets a rising-edge detector.
module spi_rx_sync #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             edge_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             rise_o
);

  logic [STAGES-1:0] sck_q;
  logic              sck_d_q;
  logic [WIDTH-1:0]  data_q [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q   <= '0;
      sck_d_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      sck_q     <= {sck_q[STAGES-2:0], edge_i};
      sck_d_q   <= sck_q[STAGES-1];
      data_q[0] <= data_i;
      for (int i = 1; i < STAGES; i++) data_q[i] <= data_q[i-1];
    end
  end

  assign data_o = data_q[STAGES-1];
  assign rise_o = sck_q[STAGES-1] & ~sck_d_q;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI target capturing one MSB-first frame into a parallel register.
// Optional error strobe (abort / overrun) is built only when SPI_RX_ERR_EN is defined.
module spi_frame_receiver
  import spi_rx_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  sdi,
  input  logic                  ce,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic [1:0]            dbg_state_o
);

  localparam int unsigned   CW          = cnt_width(FRAME_BITS);
  localparam int unsigned   SW          = cnt_width(SYNC_STAGES);
  localparam logic [CW-1:0] CNT_FULL    = CW'(FRAME_BITS);
  localparam logic [SW-1:0] SETTLE_FULL = SW'(SYNC_STAGES);

  logic ce_s, sdi_s, rise;

  spi_rx_sync #(
    .WIDTH  (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .edge_i (spi_sck),
    .data_i ({ce, sdi}),
    .data_o ({ce_s, sdi_s}),
    .rise_o (rise)
  );

  state_e                state_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d, frame_q;
  logic                  valid_q;
  logic                  armed_q;
  logic [SW-1:0]         settle_q;
  logic                  settled;

  assign shift_d = {shift_q[FRAME_BITS-2:0], sdi_s};
  assign cnt_d   = cnt_q + 1'b1;
  assign settled = (settle_q == SETTLE_FULL);

  // ce_s only means something once the synchronizer has refilled after reset;
  // a frame may start only after a genuine ce low has been seen, so a transfer
  // already in flight at reset release is never picked up in the middle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      armed_q  <= 1'b0;
      settle_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (!settled) settle_q <= settle_q + 1'b1;
      if (settled && !ce_s) armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (ce_s && armed_q) state_q <= SHIFT;
        end
        SHIFT: begin
          if (!ce_s) begin
            state_q <= IDLE;
          end else if (rise) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            if (cnt_d == CNT_FULL) begin
              frame_q <= shift_d;
              valid_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (!ce_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_RX_ERR_EN
  logic err_q, ovr_q;

  // ovr_q remembers that the first overrun bit of this DONE window was flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == SHIFT && !ce_s) err_q <= 1'b1;
      if (state_q == DONE && ce_s && rise && !ovr_q) err_q <= 1'b1;
      ovr_q <= (state_q == DONE) && (ovr_q || (ce_s && rise));
    end
  end

  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

  // frame_valid is a strobe with no back-pressure: the consumer must take
  // frame_data in the cycle it pulses, or later while it is held.
  assign frame_data  = frame_q;
  assign frame_valid = valid_q;
  assign busy        = (state_q == SHIFT);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: random frames against a bit-level frame model and scoreboard.
`timescale 1ns/1ps
module tb_spi_frame_receiver;

  localparam int FB = 512;
`ifdef SPI_RX_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          spi_sck = 1'b0;
  logic          sdi = 1'b0;
  logic          ce = 1'b0;
  logic [FB-1:0] frame_data;
  logic          frame_valid, busy, frame_err;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  spi_frame_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .sdi         (sdi),
    .ce          (ce),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .busy        (busy),
    .frame_err   (frame_err),
    .dbg_state_o (dbg_state)
  );

  int            n_checks = 0;
  int            n_fail = 0;
  int            valid_cnt = 0;
  int            err_cnt = 0;
  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] last_frame = '0;
  logic [4:1]    lat_v;

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    logic [FB-1:0] exp;
    #1;
    if (frame_err === 1'b1) err_cnt++;
    if (frame_valid === 1'b1) begin
      valid_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: frame_valid with no frame expected, got %h", frame_data);
      end else begin
        exp = exp_q.pop_front();
        if (frame_data !== exp) begin
          n_fail++;
          $display("FAIL sb_frame: got %h expected %h", frame_data, exp);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    ce = 1'b1;
    clks(4);
  endtask

  task automatic end_frame();
    ce = 1'b0;
    clks(4);
  endtask

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] r;
    for (int i = 0; i < FB / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Bits go out MSB first; bits past FB are random filler.
  task automatic send_bits(input logic [FB-1:0] data, input int nbits, input int half,
                           input bit lat_chk);
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < FB) ? data[FB-1-i] : 1'($urandom_range(0, 1));
      clks(half);
      spi_sck = 1'b1;
      if (lat_chk && i == nbits - 1) begin
        for (int e = 1; e <= 4; e++) begin
          @(posedge clk);
          #1;
          lat_v[e] = frame_valid;
        end
        clks(1);
      end else begin
        clks(half);
      end
      spi_sck = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    ce = 1'b0; spi_sck = 1'b0; sdi = 1'b0;
    clks(3);
    n_checks += 5;
    if (frame_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", frame_data); end
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", frame_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", frame_err); end
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    reset = 1'b0;
    clks(4);
    n_checks++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_idle: got %0d expected %0d", dbg_state, ST_IDLE); end
    last_frame = '0;
  endtask

  task automatic test_pattern();
    logic [FB-1:0] pat;
    int v0, e0;
    for (int k = 0; k < FB / 8; k++) pat[FB-1-8*k -: 8] = 8'(4 * k);
    v0 = valid_cnt; e0 = err_cnt;
    start_frame();
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL pat_busy_shift: got %b expected 1", busy); end
    if (dbg_state !== ST_SHIFT) begin n_fail++; $display("FAIL pat_state_shift: got %0d expected %0d", dbg_state, ST_SHIFT); end
    exp_q.push_back(pat);
    send_bits(pat, FB, 5, 1'b1);
    n_checks += 3;
    if (lat_v !== 4'b0100) begin n_fail++; $display("FAIL pat_latency: got valid edges %b expected 0100", lat_v); end
    if (dbg_state !== ST_DONE) begin n_fail++; $display("FAIL pat_state_done: got %0d expected %0d", dbg_state, ST_DONE); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL pat_busy_done: got %b expected 0", busy); end
    end_frame();
    n_checks += 4;
    if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL pat_valid_count: got %0d expected 1", valid_cnt - v0); end
    if (frame_data !== pat) begin n_fail++; $display("FAIL pat_data: got %h expected %h", frame_data, pat); end
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL pat_err: got %0d expected 0", err_cnt - e0); end
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL pat_idle: got %0d expected %0d", dbg_state, ST_IDLE); end
    last_frame = pat;
  endtask

  task automatic test_back_to_back();
    logic [FB-1:0] f1, f2;
    int v0;
    f1 = '1;
    f2 = FB'(1);
    v0 = valid_cnt;
    start_frame();
    exp_q.push_back(f1);
    send_bits(f1, FB, 3, 1'b0);
    end_frame();
    start_frame();
    exp_q.push_back(f2);
    send_bits(f2, FB, 3, 1'b0);
    end_frame();
    n_checks += 2;
    if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0); end
    if (frame_data !== f2) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", frame_data, f2); end
    last_frame = f2;
  endtask

  task automatic test_abort();
    logic [FB-1:0] r, a5;
    int v0, e0;
    r = rand_frame();
    v0 = valid_cnt; e0 = err_cnt;
    start_frame();
    send_bits(r, 100, 3, 1'b0);
    clks(3);
    ce = 1'b0;
    clks(5);
    n_checks += 4;
    if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL abort_valid: got %0d expected 0", valid_cnt - v0); end
    if (frame_data !== last_frame) begin n_fail++; $display("FAIL abort_data_held: got %h expected %h", frame_data, last_frame); end
    if (err_cnt - e0 !== ERR_EN) begin n_fail++; $display("FAIL abort_err: got %0d expected %0d", err_cnt - e0, ERR_EN); end
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_idle: got %0d expected %0d", dbg_state, ST_IDLE); end
    a5 = {(FB / 8){8'hA5}};
    start_frame();
    exp_q.push_back(a5);
    send_bits(a5, FB, 3, 1'b0);
    end_frame();
    n_checks++;
    if (frame_data !== a5) begin n_fail++; $display("FAIL abort_next_data: got %h expected %h", frame_data, a5); end
    last_frame = a5;
  endtask

  task automatic test_overrun();
    logic [FB-1:0] r;
    int v0, e0;
    r = rand_frame();
    v0 = valid_cnt; e0 = err_cnt;
    start_frame();
    exp_q.push_back(r);
    send_bits(r, FB + 3, 3, 1'b0);
    n_checks += 2;
    if (dbg_state !== ST_DONE) begin n_fail++; $display("FAIL ovr_state: got %0d expected %0d", dbg_state, ST_DONE); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_busy: got %b expected 0", busy); end
    end_frame();
    n_checks += 3;
    if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL ovr_valid_count: got %0d expected 1", valid_cnt - v0); end
    if (frame_data !== r) begin n_fail++; $display("FAIL ovr_data: got %h expected %h", frame_data, r); end
    if (err_cnt - e0 !== ERR_EN) begin n_fail++; $display("FAIL ovr_err: got %0d expected %0d", err_cnt - e0, ERR_EN); end
    last_frame = r;
  endtask

  task automatic test_reset_mid();
    logic [FB-1:0] r1, r2, r3;
    int v0, e0;
    r1 = rand_frame(); r2 = rand_frame(); r3 = rand_frame();
    start_frame();
    send_bits(r1, 300, 3, 1'b0);
    reset = 1'b1;
    #1;
    n_checks += 2;
    if (frame_data !== '0) begin n_fail++; $display("FAIL rmid_async_data: got %h expected 0", frame_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async_busy: got %b expected 0", busy); end
    clks(2);
    reset = 1'b0;
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(r2, 50, 3, 1'b0);
    clks(4);
    n_checks += 6;
    if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL rmid_valid: got %0d expected 0", valid_cnt - v0); end
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL rmid_err: got %0d expected 0", err_cnt - e0); end
    if (frame_data !== '0) begin n_fail++; $display("FAIL rmid_data: got %h expected 0", frame_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_lvl: got %b expected 0", frame_valid); end
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rmid_idle: got %0d expected %0d", dbg_state, ST_IDLE); end
    end_frame();
    start_frame();
    exp_q.push_back(r3);
    send_bits(r3, FB, 3, 1'b0);
    end_frame();
    n_checks++;
    if (frame_data !== r3) begin n_fail++; $display("FAIL rmid_recover_data: got %h expected %h", frame_data, r3); end
    last_frame = r3;
  endtask

  task automatic test_ce_race();
    logic [FB-1:0] r;
    int v0, e0;
    r = rand_frame();
    v0 = valid_cnt; e0 = err_cnt;
    start_frame();
    send_bits(r, FB - 1, 3, 1'b0);
    sdi = r[0];
    clks(3);
    spi_sck = 1'b1;
    ce = 1'b0;
    clks(3);
    spi_sck = 1'b0;
    clks(4);
    n_checks += 5;
    if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL race_valid: got %0d expected 0", valid_cnt - v0); end
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL race_idle: got %0d expected %0d", dbg_state, ST_IDLE); end
    if (frame_data !== last_frame) begin n_fail++; $display("FAIL race_data_held: got %h expected %h", frame_data, last_frame); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL race_busy: got %b expected 0", busy); end
    if (err_cnt - e0 !== ERR_EN) begin n_fail++; $display("FAIL race_err: got %0d expected %0d", err_cnt - e0, ERR_EN); end
  endtask

  task automatic test_random();
    logic [FB-1:0] r;
    int v0, half, gap;
    for (int n = 0; n < 3; n++) begin
      r = rand_frame();
      half = $urandom_range(3, 4);
      gap = $urandom_range(3, 6);
      v0 = valid_cnt;
      start_frame();
      exp_q.push_back(r);
      send_bits(r, FB, half, 1'b0);
      ce = 1'b0;
      clks(gap);
      n_checks += 2;
      if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL rand_valid_count[%0d]: got %0d expected 1", n, valid_cnt - v0); end
      if (frame_data !== r) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", n, frame_data, r); end
      last_frame = r;
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_reset_mid();
    test_ce_race();
    test_random();
    clks(4);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: got %0d frames outstanding expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
